spi_regfile: RTL and testbench

Parametrised SPI configuration register file, the successor to the fixed 256×32 write-only config RAM. It sits behind `spi_slave`'s byte-stream handshake and decodes framed write and read commands into a register array of configurable depth and width. It exposes the array as a flat bus plus a per-write strobe for downstream DDS/DRG/ADC control logic. Reset clears every register to zero immediately, with no sequential clear sweep.

---
 rtl/spi_regfile.sv | 162 ++++++++++++++++
 tb/tb_spi_regfile.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile.sv
// SPI framed register file: decodes write/read byte frames into a flat register bank.
// Optional trailing CRC-8 on write frames when SPI_REGFILE_CRC_EN is defined.
module spi_regfile #(
    parameter int         ADDR_WIDTH = 8,
    parameter int         NUM_REGS   = 64,
    parameter int         DATA_BYTES = 4,
    parameter logic [7:0] SYNC_WR    = 8'h5A,
    parameter logic [7:0] SYNC_RD    = 8'hA5
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             cs_n,
    input  logic                             rx_valid,
    output logic                             rx_ready,
    input  logic [7:0]                       rx_data,
    output logic [7:0]                       tx_data,
    output logic [NUM_REGS*DATA_BYTES*8-1:0] reg_flat,
    output logic                             wr_strobe,
    output logic [ADDR_WIDTH-1:0]            wr_addr,
    output logic [8*DATA_BYTES-1:0]          wr_data,
    output logic                             err_addr
`ifdef SPI_REGFILE_CRC_EN
    ,
    output logic                             err_crc
`endif
);
    localparam int W     = 8 * DATA_BYTES;
    localparam int BC_W  = $clog2(DATA_BYTES + 1);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_WADDR  = 3'd2;
    localparam logic [2:0] S_WDATA  = 3'd3;
    localparam logic [2:0] S_CRC    = 3'd4;
    localparam logic [2:0] S_COMMIT = 3'd5;
    localparam logic [2:0] S_RADDR  = 3'd6;
    localparam logic [2:0] S_RDATA  = 3'd7;

    logic [2:0]            state, next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BC_W-1:0]       bc;
    logic [W-1:0]          data_buf;
    logic                  hs, last_byte, in_range, rx_in_range;
    logic [IDX_W-1:0]      idx;

    assign hs          = rx_valid && rx_ready;
    assign last_byte   = (bc == BC_W'(DATA_BYTES - 1));
    assign in_range    = int'(addr) < NUM_REGS;
    assign rx_in_range = int'(rx_data[ADDR_WIDTH-1:0]) < NUM_REGS;
    assign idx         = addr[IDX_W-1:0];

`ifdef SPI_REGFILE_CRC_EN
    logic [7:0] crc;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] x;
        x = c ^ b;
        for (int i = 0; i < 8; i++)
            x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        return x;
    endfunction
`endif

    always_comb begin
        next = state;
        case (state)
            S_RESET:  next = S_IDLE;
            S_IDLE: begin
                if (hs && rx_data == SYNC_WR)      next = S_WADDR;
                else if (hs && rx_data == SYNC_RD) next = S_RADDR;
            end
            S_WADDR:  if (hs) next = S_WDATA;
`ifdef SPI_REGFILE_CRC_EN
            S_WDATA:  if (hs && last_byte) next = S_CRC;
            S_CRC:    if (hs) next = (rx_data == crc) ? S_COMMIT : S_IDLE;
`else
            S_WDATA:  if (hs && last_byte) next = S_COMMIT;
`endif
            S_COMMIT: next = S_IDLE;
            S_RADDR:  if (hs) next = S_RDATA;
            S_RDATA:  if (hs && last_byte) next = S_IDLE;
            default:  next = S_IDLE;
        endcase
        if (cs_n) next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_RESET;
            rx_ready  <= 1'b0;
            addr      <= '0;
            bc        <= '0;
            data_buf  <= '0;
            tx_data   <= 8'h00;
            reg_flat  <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            err_addr  <= 1'b0;
`ifdef SPI_REGFILE_CRC_EN
            crc       <= 8'h00;
            err_crc   <= 1'b0;
`endif
        end else begin
            state     <= next;
            // Registered from next state so the first IDLE cycle after reset and COMMIT refuse bytes.
            rx_ready  <= (state != S_RESET) && (next != S_COMMIT);
            wr_strobe <= 1'b0;
            err_addr  <= 1'b0;
            tx_data   <= 8'h00;
`ifdef SPI_REGFILE_CRC_EN
            err_crc   <= 1'b0;
`endif
            if (cs_n) begin
                bc <= '0;
            end else begin
                case (state)
                    S_IDLE: bc <= '0;
                    S_WADDR: if (hs) begin
                        addr <= rx_data[ADDR_WIDTH-1:0];
                        bc   <= '0;
`ifdef SPI_REGFILE_CRC_EN
                        crc  <= crc8_step(8'h00, rx_data);
`endif
                    end
                    S_WDATA: if (hs) begin
                        data_buf[bc*8 +: 8] <= rx_data;
                        bc                  <= bc + BC_W'(1);
`ifdef SPI_REGFILE_CRC_EN
                        crc                 <= crc8_step(crc, rx_data);
`endif
                    end
`ifdef SPI_REGFILE_CRC_EN
                    S_CRC: if (hs && rx_data != crc) err_crc <= 1'b1;
`endif
                    S_COMMIT: begin
                        if (in_range) begin
                            reg_flat[idx*W +: W] <= data_buf;
                            wr_strobe            <= 1'b1;
                            wr_addr              <= addr;
                            wr_data              <= data_buf;
                        end else begin
                            err_addr <= 1'b1;
                        end
                    end
                    S_RADDR: if (hs) begin
                        addr <= rx_data[ADDR_WIDTH-1:0];
                        bc   <= '0;
                        if (!rx_in_range) err_addr <= 1'b1;
                    end
                    S_RDATA: begin
                        if (in_range && int'(bc) < DATA_BYTES)
                            tx_data <= reg_flat[idx*W + bc*8 +: 8];
                        if (hs) bc <= bc + BC_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_regfile.sv
// Directed bench for spi_regfile: reset, table-driven write/read frames, abort and CRC sequences.
module tb_spi_regfile;
    localparam int NR = 64;
    localparam int DB = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              cs_n = 1'b0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic [7:0]        rx_data = 8'h00;
    logic [7:0]        tx_data;
    logic [NR*DB*8-1:0] reg_flat;
    logic              wr_strobe;
    logic [7:0]        wr_addr;
    logic [31:0]       wr_data;
    logic              err_addr;
`ifdef SPI_REGFILE_CRC_EN
    logic              err_crc;
`endif

    spi_regfile dut (
        .clk(clk), .rstn(rstn), .cs_n(cs_n),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .tx_data(tx_data), .reg_flat(reg_flat),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .err_addr(err_addr)
`ifdef SPI_REGFILE_CRC_EN
        , .err_crc(err_crc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        ok;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] model[NR];
    int          checks = 0;
    int          errors = 0;
    int          strobe_cnt = 0;
    int          exp_strobes = 0;

    always @(negedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_flat(input string name);
        int bad;
        bad = -1;
        for (int k = 0; k < NR; k++)
            if (bad < 0 && reg_flat[k*32 +: 32] !== model[k]) bad = k;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: reg[%0d] got %h expected %h", name, bad, reg_flat[bad*32 +: 32], model[bad]);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that took the byte.
    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && t < 16) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 16) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %h not accepted, rx_ready %b expected 1", b, rx_ready);
        end else begin
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
    endtask

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] x;
        x = c ^ b;
        for (int i = 0; i < 8; i++)
            x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        return x;
    endfunction

    function automatic logic [7:0] frame_crc(input logic [7:0] a, input logic [31:0] d);
        logic [7:0] c;
        c = crc8(8'h00, a);
        for (int i = 0; i < 4; i++) c = crc8(c, d[i*8 +: 8]);
        return c;
    endfunction

    task automatic wr_frame(input logic [7:0] a, input logic [31:0] d);
        send(8'h5A);
        send(a);
        for (int i = 0; i < 4; i++) send(d[i*8 +: 8]);
`ifdef SPI_REGFILE_CRC_EN
        send(frame_crc(a, d));
`endif
    endtask

    initial begin
        vecs[0] = '{8'h05, 32'h12345678, 1'b1};
        vecs[1] = '{8'h00, 32'hDEADBEEF, 1'b1};
        vecs[2] = '{8'h3F, 32'hCAFEF00D, 1'b1};
        vecs[3] = '{8'h40, 32'h11111111, 1'b0};
        vecs[4] = '{8'hFF, 32'h22222222, 1'b0};
        vecs[5] = '{8'h3E, 32'hA5A55A5A, 1'b1};
        for (int k = 0; k < NR; k++) model[k] = 32'h0;

        #12;
        chk_flat("reset_regs");
        chk("reset_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("reset_tx_data", {24'd0, tx_data}, 32'd0);
        chk("reset_wr_strobe", {31'd0, wr_strobe}, 32'd0);
        chk("reset_err_addr", {31'd0, err_addr}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("rx_ready_1cyc", {31'd0, rx_ready}, 32'd0);
        @(posedge clk); #1;
        chk("rx_ready_2cyc", {31'd0, rx_ready}, 32'd1);
        chk("idle_tx_data", {24'd0, tx_data}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            wr_frame(vecs[i].addr, vecs[i].data);
            chk("commit_rx_ready", {31'd0, rx_ready}, 32'd0);
            chk("commit_pre_strobe", {31'd0, wr_strobe}, 32'd0);
            @(posedge clk); #1;
            chk("wr_strobe", {31'd0, wr_strobe}, {31'd0, vecs[i].ok});
            chk("wr_err_addr", {31'd0, err_addr}, {31'd0, ~vecs[i].ok});
            if (vecs[i].ok) begin
                chk("wr_addr", {24'd0, wr_addr}, {24'd0, vecs[i].addr});
                chk("wr_data", wr_data, vecs[i].data);
                model[vecs[i].addr[5:0]] = vecs[i].data;
                exp_strobes++;
            end
            chk_flat("wr_regs");
            @(posedge clk); #1;
            chk("wr_strobe_drop", {31'd0, wr_strobe}, 32'd0);
            chk("err_addr_drop", {31'd0, err_addr}, 32'd0);
        end
        chk("strobe_count_writes", strobe_cnt, exp_strobes);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] exp;
            exp = vecs[i].ok ? model[vecs[i].addr[5:0]] : 32'h0;
            send(8'hA5);
            send(vecs[i].addr);
            chk("rd_err_addr", {31'd0, err_addr}, {31'd0, ~vecs[i].ok});
            @(posedge clk); #1;
            for (int b = 0; b < 4; b++) begin
                chk("rd_tx_byte", {24'd0, tx_data}, {24'd0, exp[b*8 +: 8]});
                send(8'hC3);
                @(posedge clk); #1;
            end
            chk("rd_tx_idle", {24'd0, tx_data}, 32'd0);
        end

        send(8'h5A);
        send(8'h03);
        send(8'h11);
        send(8'h22);
        cs_n = 1'b1;
        @(posedge clk); #1;
        cs_n = 1'b0;
        @(posedge clk); #1;
        chk_flat("abort_regs");
        chk("abort_tx", {24'd0, tx_data}, 32'd0);
        chk("abort_no_strobe", strobe_cnt, exp_strobes);
        wr_frame(8'h03, 32'hDDCCBBAA);
        @(posedge clk); #1;
        @(posedge clk); #1;
        model[3] = 32'hDDCCBBAA;
        exp_strobes++;
        chk_flat("after_abort_regs");
        chk("after_abort_strobes", strobe_cnt, exp_strobes);

`ifdef SPI_REGFILE_CRC_EN
        wr_frame(8'h07, 32'h0BADF00D);
        @(posedge clk); #1;
        chk("crc_ok_strobe", {31'd0, wr_strobe}, 32'd1);
        @(posedge clk); #1;
        model[7] = 32'h0BADF00D;
        exp_strobes++;
        chk_flat("crc_ok_regs");
        send(8'h5A);
        send(8'h08);
        for (int i = 0; i < 4; i++) send(8'h3C + 8'(i));
        send(frame_crc(8'h08, 32'h3F3E3D3C) ^ 8'h01);
        chk("crc_bad_err", {31'd0, err_crc}, 32'd1);
        @(posedge clk); #1;
        chk("crc_bad_err_drop", {31'd0, err_crc}, 32'd0);
        @(posedge clk); #1;
        chk_flat("crc_bad_regs");
        chk("crc_bad_strobes", strobe_cnt, exp_strobes);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
